bank_stream_reader: RTL and testbench

- Read initiator for one port of a GEMM operand bank (dual-port BRAM, 1-cycle registered read, enable-gated output).
- Walks a contiguous address range: issues en/addr to the bank, absorbs the fixed read latency and delivers words on a valid/ready stream with a last marker.
- Feeds the systolic-array input skew logic. One instance is used per bank.

---
 rtl/bank_stream_reader.sv | 140 ++++++++++++++
 tb/tb_bank_stream_reader.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bank_stream_reader.sv
// bank_stream_reader: walks a bank address range and streams the read words out through a 2-entry buffer.
// Optional `define BANK_RD_STRIDE_EN adds a per-transfer address stride port; otherwise the stride is 1.
module bank_stream_reader #(
  parameter int A_WID   = 10,
  parameter int D_WID   = 8,
  parameter int LEN_WID = 11
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [A_WID-1:0]   base_addr,
  input  logic [LEN_WID-1:0] len,
`ifdef BANK_RD_STRIDE_EN
  input  logic [A_WID-1:0]   stride,
`endif
  output logic               busy,
  output logic               done,
  output logic               mem_en,
  output logic [A_WID-1:0]   mem_addr,
  input  logic [D_WID-1:0]   mem_din,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [D_WID-1:0]   out_data,
  output logic               out_last
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_e;

  state_e             state_q, state_d;
  logic [LEN_WID-1:0] len_q, len_d;
  logic [LEN_WID-1:0] issued_q, issued_d;
  logic [A_WID-1:0]   next_addr_q, next_addr_d;
  logic [A_WID-1:0]   last_addr_q, last_addr_d;
  logic [A_WID-1:0]   step;
  logic               inflight_q, inflight_last_q;
  logic [D_WID-1:0]   buf_data_q [2];
  logic [1:0]         buf_last_q;
  logic               head_q;
  logic [1:0]         count_q;
  logic               pop, tail, issue_last, start_ok;
  logic [2:0]         occupancy;

  assign start_ok = (state_q == IDLE) && start;

`ifdef BANK_RD_STRIDE_EN
  logic [A_WID-1:0] stride_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stride_q <= '0;
    end else if (start_ok) begin
      stride_q <= stride;
    end
  end

  assign step = stride_q;
`else
  assign step = A_WID'(1);
`endif

  assign out_valid = (count_q != 2'd0);
  assign pop       = out_valid && out_ready;
  assign out_data  = buf_data_q[head_q];
  assign out_last  = out_valid && buf_last_q[head_q];
  assign busy      = (state_q == RUN);
  assign done      = (state_q == FIN);

  // Credit check counts the word still coming back from the bank so the buffer cannot overflow.
  assign occupancy  = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign mem_en     = (state_q == RUN) && (issued_q < len_q) && (occupancy < 3'd2);
  assign issue_last = ((issued_q + LEN_WID'(1)) == len_q);
  assign mem_addr   = mem_en ? next_addr_q : last_addr_q;
  assign tail       = head_q ^ count_q[0];

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    issued_d    = issued_q;
    next_addr_d = next_addr_q;
    last_addr_d = last_addr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          len_d       = len;
          issued_d    = '0;
          next_addr_d = base_addr;
          state_d     = (len == '0) ? FIN : RUN;
        end
      end
      RUN: begin
        if (pop && out_last) state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (mem_en) begin
      issued_d    = issued_q + LEN_WID'(1);
      next_addr_d = next_addr_q + step;
      last_addr_d = next_addr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      len_q           <= '0;
      issued_q        <= '0;
      next_addr_q     <= '0;
      last_addr_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      len_q           <= len_d;
      issued_q        <= issued_d;
      next_addr_q     <= next_addr_d;
      last_addr_q     <= last_addr_d;
      inflight_q      <= mem_en;
      inflight_last_q <= mem_en && issue_last;
    end
  end

  // The returning bank word lands at the tail; at most one push and one pop per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) buf_data_q[i] <= '0;
      buf_last_q <= '0;
      head_q     <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      if (inflight_q) begin
        buf_data_q[tail] <= mem_din;
        buf_last_q[tail] <= inflight_last_q;
      end
      head_q  <= head_q ^ pop;
      count_q <= count_q + {1'b0, inflight_q} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_bank_stream_reader.sv
// Testbench for bank_stream_reader: table-driven transfers, corner-case sequences and random transfers
// checked against a queue-based model of the expected address and word sequence.
module tb_bank_stream_reader;
  localparam int AW = 10;
  localparam int DW = 8;
  localparam int LW = 11;

  logic          clk = 1'b0;
  logic          rst_n, start, out_ready;
  logic [AW-1:0] base_addr;
  logic [LW-1:0] len;
`ifdef BANK_RD_STRIDE_EN
  logic [AW-1:0] stride;
`endif
  logic          busy, done, mem_en, out_valid, out_last;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, out_data;
  logic [DW-1:0] mem [1024];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bank_stream_reader #(.A_WID(AW), .D_WID(DW), .LEN_WID(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
`ifdef BANK_RD_STRIDE_EN
    .stride(stride),
`endif
    .busy(busy), .done(done), .mem_en(mem_en), .mem_addr(mem_addr), .mem_din(mem_din),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  // Bank port: one-cycle registered read, output holds while disabled.
  always @(posedge clk) begin
    if (mem_en) mem_din <= mem[mem_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic xfer(input logic [AW-1:0] b, input logic [LW-1:0] l, input logic [AW-1:0] st,
                      input int mode, input bit mid_start,
                      output logic [DW-1:0] first_d, output logic [DW-1:0] last_d, output int done_cyc);
    logic [DW-1:0] exp_q[$];
    logic [AW-1:0] adr_q[$];
    logic [AW-1:0] a;
    logic [DW-1:0] exp_d, prev_data;
    logic          prev_stall;
    int            pops, issues, first_en, first_val, last_hs, ndone;
    a = b;
    for (int k = 0; k < int'(l); k++) begin
      adr_q.push_back(a);
      exp_q.push_back(mem[a]);
      a = a + st;
    end
    first_d = '0; last_d = '0; done_cyc = -1;
    pops = 0; issues = 0; first_en = -1; first_val = -1; last_hs = -1; ndone = 0;
    prev_stall = 1'b0; prev_data = '0;
    @(negedge clk);
    start = 1'b1; base_addr = b; len = l; out_ready = 1'b0;
`ifdef BANK_RD_STRIDE_EN
    stride = st;
`endif
    @(negedge clk);
    for (int n = 1; n < 3000; n++) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (n % 3 == 0);
        default: out_ready = 1'($urandom % 2);
      endcase
      if (mid_start && n == 4) begin
        start = 1'b1; base_addr = b + 10'd100; len = 11'd2;
      end else begin
        start = 1'b0;
      end
      #1;
      if (prev_stall) begin
        chk("stall_hold_valid", out_valid, 1);
        chk("stall_hold_data", out_data, prev_data);
      end
      if (out_valid && first_val < 0) first_val = n;
      if (mem_en) begin
        issues++;
        if (first_en < 0) first_en = n;
        if (adr_q.size() == 0) chk("extra_issue", issues, l);
        else chk("mem_addr", mem_addr, adr_q.pop_front());
      end
      if (out_valid && out_ready) begin
        pops++;
        if (exp_q.size() == 0) begin
          chk("extra_word", pops, l);
        end else begin
          exp_d = exp_q.pop_front();
          chk("out_data", out_data, exp_d);
          chk("out_last", out_last, exp_q.size() == 0);
          if (pops == 1) first_d = out_data;
          last_d = out_data;
          last_hs = n;
        end
      end
      if (mem_en) chk("outstanding_le2", 32'(issues - pops <= 2), 1);
      if (done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = n;
        chk("busy_at_done", busy, 0);
      end else if (l != 0 && done_cyc < 0) begin
        chk("busy_in_run", busy, 1);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (done_cyc >= 0 && n >= done_cyc + 2) break;
      @(negedge clk);
    end
    start = 1'b0;
    out_ready = 1'b0;
    chk("done_pulses", ndone, 1);
    chk("word_count", pops, l);
    chk("issue_count", issues, l);
    if (l != 0) begin
      chk("first_en_cycle", first_en, 1);
      chk("first_valid_cycle", first_val, 3);
      chk("done_after_last", done_cyc, last_hs + 1);
    end else begin
      chk("len0_no_issue", issues, 0);
      chk("len0_done_cycle", done_cyc, 1);
    end
    $display("xfer base=%03h len=%0d stride=%0h mode=%0d words=%0d done_cycle=%0d",
             b, l, st, mode, pops, done_cyc);
  endtask

  typedef struct {
    logic [AW-1:0] base;
    logic [LW-1:0] len;
    int            mode;
    logic [DW-1:0] exp_first;
    logic [DW-1:0] exp_last;
    int            exp_done;
  } vec_t;

  vec_t vt[6];

  initial begin
    #400_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] fd, ld;
    int            dc, hs;
    logic [AW-1:0] rst_st;

    vt[0] = '{10'h010, 11'd4,    0, 8'h10, 8'h13, 7};
    vt[1] = '{10'h3FE, 11'd4,    0, 8'hFE, 8'h01, 7};
    vt[2] = '{10'h000, 11'd0,    0, 8'h00, 8'h00, 1};
    vt[3] = '{10'h100, 11'd8,    1, 8'h00, 8'h07, -1};
    vt[4] = '{10'h3FF, 11'd1,    0, 8'hFF, 8'hFF, 4};
    vt[5] = '{10'h005, 11'd1024, 0, 8'h05, 8'h04, 1027};

    for (int k = 0; k < 1024; k++) mem[k] = k[7:0];
    rst_n = 1'b1; start = 1'b0; out_ready = 1'b0; base_addr = '0; len = '0;
`ifdef BANK_RD_STRIDE_EN
    stride = '0;
`endif
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      xfer(vt[i].base, vt[i].len, 10'd1, vt[i].mode, 1'b0, fd, ld, dc);
      chk("vec_first_data", fd, vt[i].exp_first);
      chk("vec_last_data", ld, vt[i].exp_last);
      if (vt[i].exp_done >= 0) chk("vec_done_cycle", dc, vt[i].exp_done);
    end

`ifdef BANK_RD_STRIDE_EN
    xfer(10'h000, 11'd3, 10'h004, 0, 1'b0, fd, ld, dc);
    chk("stride_first", fd, 8'h00);
    chk("stride_last", ld, 8'h08);
    xfer(10'h033, 11'd3, 10'h000, 1, 1'b0, fd, ld, dc);
    chk("stride0_last", ld, 8'h33);
`endif

    // Second start while running must be ignored.
    xfer(10'h040, 11'd6, 10'd1, 2, 1'b1, fd, ld, dc);
    chk("midstart_last", ld, 8'h45);

    // Reset after the third word: everything clears at once and no done follows.
    @(negedge clk);
    start = 1'b1; base_addr = 10'h020; len = 11'd6;
`ifdef BANK_RD_STRIDE_EN
    stride = 10'd1;
`endif
    @(negedge clk);
    start = 1'b0;
    hs = 0;
    for (int n = 0; n < 40 && hs < 3; n++) begin
      out_ready = 1'b1;
      #1;
      if (out_valid) hs++;
      @(negedge clk);
    end
    chk("pre_reset_words", hs, 3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_mem_en", mem_en, 0);
    chk("mid_rst_mem_addr", mem_addr, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_out_last", out_last, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      #1;
      chk("post_rst_no_done", done, 0);
      chk("post_rst_idle_valid", out_valid, 0);
    end
    out_ready = 1'b0;
    xfer(10'h200, 11'd5, 10'd1, 0, 1'b0, fd, ld, dc);
    chk("after_rst_first", fd, 8'h00);
    chk("after_rst_done", dc, 8);

    // Random memory contents and random transfers.
    for (int k = 0; k < 1024; k++) mem[k] = 8'($urandom);
    for (int r = 0; r < 25; r++) begin
`ifdef BANK_RD_STRIDE_EN
      rst_st = 10'($urandom_range(0, 7));
`else
      rst_st = 10'd1;
`endif
      xfer(10'($urandom), 11'($urandom_range(0, 20)), rst_st, int'($urandom_range(0, 2)), 1'b0, fd, ld, dc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
